// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port SRAM controller with valid/ready request and response
// handshakes, per-bit write mask, a held response register for back-pressure and
// a post-reset sequencer that zeroes the whole array before traffic is accepted.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   REQ_VALID  request present
//   REQ_READY  request accepted when REQ_VALID && REQ_READY
//   REQ_WE     1 = write, 0 = read
//   REQ_ADR    word address
//   REQ_D      write data
//   REQ_MASK   per-bit write enable (1 = write the bit)
//   RSP_VALID  read data valid
//   RSP_READY  consumer takes RSP_Q when RSP_VALID && RSP_READY
//   RSP_Q      read data
//   INIT_DONE  clear finished, traffic allowed
module sram_ctrl #(
    parameter int unsigned DATA_W     = 39,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [ADDR_W-1:0] REQ_ADR,
    input  logic [DATA_W-1:0] REQ_D,
    input  logic [DATA_W-1:0] REQ_MASK,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_Q,
    output logic              INIT_DONE
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    // Extra MSB flags that every address has been written.
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_wmask;
    logic              rd_en;
    logic              accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_adr   = REQ_ADR;
        mem_wdata = REQ_D;
        mem_wmask = REQ_MASK;
        REQ_READY = 1'b0;
        accept    = 1'b0;
        rd_en     = 1'b0;
        unique case (state_q)
            StClear: begin
                if (INIT_CLEAR == 0 || cnt_q[ADDR_W]) begin
                    state_d = StRun;
                end else begin
                    mem_we    = 1'b1;
                    mem_adr   = cnt_q[ADDR_W-1:0];
                    mem_wdata = '0;
                    mem_wmask = '1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            StRun: begin
                // Writes stall with reads: a held response blocks every request.
                REQ_READY = !rsp_valid_q || RSP_READY;
                accept    = REQ_VALID && REQ_READY;
                mem_we    = accept && REQ_WE;
                rd_en     = accept && !REQ_WE;
            end
            default: state_d = StClear;
        endcase

        if (rd_en) begin
            rsp_valid_d = 1'b1;
        end else if (RSP_READY) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StClear;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            if (rd_en) begin
                rsp_data_q <= mem[REQ_ADR];
            end
        end
    end

    // Array has no reset; only the clear sequence initialises it.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            mem[mem_adr] <= (mem[mem_adr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_Q     = rsp_data_q;
    assign INIT_DONE = (state_q == StRun);

endmodule
